key_action_scheduler: RTL and testbench

KEY_ACTION_SCHEDULER -- requirements
Module: key_action_scheduler

---
 rtl/tetris_pkg.sv | 23 ++
 rtl/key_repeat_timer.sv | 48 ++++
 rtl/key_action_scheduler.sv | 67 ++++++
 tb/tb_key_action_scheduler.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/tetris_pkg.sv
// tetris_pkg: key codes, action codes and repeat-FSM states shared by the key scheduler
package tetris_pkg;
   localparam logic [2:0] KEY_NONE  = 3'd0;
   localparam logic [2:0] KEY_ESC   = 3'd1;
   localparam logic [2:0] KEY_SPACE = 3'd2;
   localparam logic [2:0] KEY_UP    = 3'd3;
   localparam logic [2:0] KEY_DOWN  = 3'd4;
   localparam logic [2:0] KEY_LEFT  = 3'd5;
   localparam logic [2:0] KEY_RIGHT = 3'd6;
   localparam logic [2:0] KEY_OTHER = 3'd7;
   localparam logic [2:0] ACT_NONE      = 3'd0;
   localparam logic [2:0] ACT_PAUSE     = 3'd1;
   localparam logic [2:0] ACT_HARD_DROP = 3'd2;
   localparam logic [2:0] ACT_ROTATE    = 3'd3;
   localparam logic [2:0] ACT_SOFT_DROP = 3'd4;
   localparam logic [2:0] ACT_LEFT      = 3'd5;
   localparam logic [2:0] ACT_RIGHT     = 3'd6;
   localparam logic [2:0] ACT_GRAVITY   = 3'd7;
   typedef enum logic [1:0] {ST_IDLE, ST_DAS, ST_REPEAT} rep_state_e;
   function automatic logic is_repeatable(input logic [2:0] k);
      return k >= KEY_DOWN && k <= KEY_RIGHT;
   endfunction
endpackage

// File: rtl/key_repeat_timer.sv
// key_repeat_timer: DAS/ARR auto-repeat FSM for held down/left/right keys
//   clk, rst     : clock, async active-high reset
//   enable       : game running; 0 holds the FSM in IDLE
//   key_chg      : key differs from its registered previous value
//   key          : current key code
//   rep_evt      : one-cycle auto-repeat request for the held key
module key_repeat_timer
   import tetris_pkg::*;
#(
   parameter int unsigned DAS_DELAY  = 10_000_000,
   parameter int unsigned ARR_PERIOD = 3_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic       key_chg,
   input  logic [2:0] key,
   output logic       rep_evt
);
   localparam logic [31:0] DAS_TERM = 32'(DAS_DELAY - 1);
   localparam logic [31:0] ARR_TERM = 32'(ARR_PERIOD - 1);
   rep_state_e  state_q, state_d;
   logic [31:0] cnt_q, cnt_d;
   logic        at_term;
   always_comb begin
      state_d = state_q;
      cnt_d   = 32'd0;
      rep_evt = 1'b0;
      at_term = cnt_q == (state_q == ST_DAS ? DAS_TERM : ARR_TERM);
      if (!enable) state_d = ST_IDLE;
      else if (key_chg) state_d = is_repeatable(key) ? ST_DAS : ST_IDLE;
      else if (state_q != ST_IDLE) begin
         // the counter stops at its terminal value and reloads to 0 there, so it never wraps
         rep_evt = at_term;
         state_d = at_term ? ST_REPEAT : state_q;
         cnt_d   = at_term ? 32'd0 : cnt_q + 32'd1;
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end
endmodule

// File: rtl/key_action_scheduler.sv
// key_action_scheduler: turns key presses, auto-repeats and gravity ticks into a valid/ready action stream
//   clk, rst      : clock, async active-high reset
//   key           : decoded key code (synchronous to clk)
//   gravity_tick  : single-cycle gravity request
//   enable        : game running; 0 = paused
//   action_ready  : consumer accepts the presented action
//   action_valid  : an action is presented
//   action        : action code
module key_action_scheduler
   import tetris_pkg::*;
#(
   parameter int unsigned DAS_DELAY  = 10_000_000,
   parameter int unsigned ARR_PERIOD = 3_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] key,
   input  logic       gravity_tick,
   input  logic       enable,
   input  logic       action_ready,
   output logic       action_valid,
   output logic [2:0] action
);
   logic [2:0] key_q, key_d, pend_code_q, pend_code_d, action_q, action_d;
   logic       pend_v_q, pend_v_d, grav_pend_q, grav_pend_d, action_valid_q, action_valid_d;
   logic       key_chg, key_evt, rep_evt, new_evt, key_avail, load, sel_key, sel_grav;
   key_repeat_timer #(.DAS_DELAY(DAS_DELAY), .ARR_PERIOD(ARR_PERIOD)) u_timer (
      .clk(clk), .rst(rst), .enable(enable), .key_chg(key_chg), .key(key), .rep_evt(rep_evt)
   );
   always_comb begin
      key_d     = key;
      key_chg   = key != key_q;
      key_evt   = key_chg && key != KEY_NONE && key != KEY_OTHER && (enable || key == KEY_ESC);
      new_evt   = key_evt || rep_evt;
      // while paused only a pending PAUSE may leave the key slot
      key_avail = pend_v_q && (enable || pend_code_q == ACT_PAUSE);
      load      = !action_valid_q || action_ready;
      // one key slot holds at most one code, so PAUSE/HARD_DROP/other priority reduces to key-before-gravity
      sel_key   = load && key_avail;
      sel_grav  = load && !key_avail && grav_pend_q;
      // key codes map one-to-one onto action codes; a repeat re-issues the held key
      pend_code_d    = key_evt ? key : rep_evt ? key_q : pend_code_q;
      pend_v_d       = (new_evt || (pend_v_q && !sel_key)) && (enable || pend_code_d == ACT_PAUSE);
      grav_pend_d    = (gravity_tick && enable) || (grav_pend_q && !sel_grav);
      action_valid_d = load ? sel_key || sel_grav : action_valid_q;
      action_d       = !load ? action_q : sel_key ? pend_code_q : sel_grav ? ACT_GRAVITY : ACT_NONE;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         key_q          <= KEY_NONE;
         pend_v_q       <= 1'b0;
         pend_code_q    <= ACT_NONE;
         grav_pend_q    <= 1'b0;
         action_valid_q <= 1'b0;
         action_q       <= ACT_NONE;
      end else begin
         key_q          <= key_d;
         pend_v_q       <= pend_v_d;
         pend_code_q    <= pend_code_d;
         grav_pend_q    <= grav_pend_d;
         action_valid_q <= action_valid_d;
         action_q       <= action_d;
      end
   end
   assign action_valid = action_valid_q;
   assign action       = action_q;
endmodule

// File: tb/tb_key_action_scheduler.sv
// tb_key_action_scheduler: directed scenarios plus random traffic against a behavioural model
module tb_key_action_scheduler;
   localparam int DAS = 4;
   localparam int ARR = 2;
   logic       clk = 1'b0, rst = 1'b0;
   logic [2:0] key = 3'd0;
   logic       gravity_tick = 1'b0, enable = 1'b1, action_ready = 1'b1;
   logic       action_valid;
   logic [2:0] action;
   int checks = 0, errors = 0;
   int acc[8];
   int m_prev, m_age, m_pcode, m_oa;
   bit m_armed, m_pv, m_grav, m_ov;

   key_action_scheduler #(.DAS_DELAY(DAS), .ARR_PERIOD(ARR)) dut (
      .clk(clk), .rst(rst), .key(key), .gravity_tick(gravity_tick), .enable(enable),
      .action_ready(action_ready), .action_valid(action_valid), .action(action)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got %0d exp %0d", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_prev = 0; m_age = 0; m_pcode = 0; m_oa = 0;
      m_armed = 0; m_pv = 0; m_grav = 0; m_ov = 0;
   endtask

   // Model: a held repeatable key fires when its age since the press reaches DAS-1, then every ARR cycles.
   task automatic model_edge(input int k, input bit t, input bit e, input bit r);
      bit evt, rep, ck, cg;
      evt = k != m_prev && k >= 1 && k <= 6 && (e || k == 1);
      rep = m_armed && e && k == m_prev && m_age >= DAS - 1 && (m_age - (DAS - 1)) % ARR == 0;
      ck = 0; cg = 0;
      if (!m_ov || r) begin
         if (m_pv && (e || m_pcode == 1)) begin m_ov = 1; m_oa = m_pcode; ck = 1; end
         else if (m_grav) begin m_ov = 1; m_oa = 7; cg = 1; end
         else begin m_ov = 0; m_oa = 0; end
      end
      if (evt || rep) begin m_pv = 1; m_pcode = evt ? k : m_prev; end
      else if (ck) m_pv = 0;
      if (!e && m_pcode != 1) m_pv = 0;
      m_grav = (t && e) || (m_grav && !cg);
      if (k != m_prev) begin m_armed = k >= 4 && k <= 6; m_age = 0; end
      else m_age++;
      if (!e) m_armed = 0;
      m_prev = k;
   endtask

   task automatic step(input int k, input bit t, input bit e, input bit r);
      key = 3'(k); gravity_tick = t; enable = e; action_ready = r;
      if (action_valid && r) acc[action]++;
      @(posedge clk);
      model_edge(k, t, e, r);
      #1;
      chk("valid", 32'(action_valid), 32'(m_ov));
      chk("action", 32'(action), 32'(m_oa));
   endtask

   task automatic do_reset();
      #2 rst = 1'b1;
      #1;
      chk("rst_valid", 32'(action_valid), 0);
      chk("rst_action", 32'(action), 0);
      model_reset();
      @(posedge clk);
      #2 rst = 1'b0;
   endtask

   task automatic clr_acc();
      for (int i = 0; i < 8; i++) acc[i] = 0;
   endtask

   initial begin
      int mask;
      int k;
      bit e;
      model_reset();
      clr_acc();
      do_reset();
      repeat (3) step(0, 0, 1, 1);
      // held LEFT: first action at edge 2, repeats at 6, 8, 10, 12
      mask = 0;
      for (int i = 1; i <= 14; i++) begin
         step(i <= 12 ? 5 : 0, 0, 1, 1);
         if (action_valid && action == 3'd5) mask |= 1 << i;
      end
      chk("left_mask", 32'(mask), 32'(5444));
      // ROTATE is one-shot
      clr_acc();
      repeat (20) step(3, 0, 1, 1);
      repeat (2) step(0, 0, 1, 1);
      chk("rotate_once", 32'(acc[3]), 1);
      repeat (4) step(3, 0, 1, 1);
      repeat (3) step(0, 0, 1, 1);
      chk("rotate_twice", 32'(acc[3]), 2);
      // key and gravity together: HARD_DROP then GRAVITY
      step(2, 1, 1, 1);
      step(0, 0, 1, 1);
      chk("hd_first", 32'(action), 2);
      step(0, 0, 1, 1);
      chk("grav_next", 32'(action), 7);
      repeat (2) step(0, 0, 1, 1);
      // stall with gravity ticks coalescing
      clr_acc();
      step(5, 0, 1, 0);
      step(0, 0, 1, 0);
      for (int i = 0; i < 10; i++) step(0, i % 3 == 1, 1, 0);
      repeat (5) step(0, 0, 1, 1);
      chk("left_once", 32'(acc[5]), 1);
      chk("grav_once", 32'(acc[7]), 1);
      // paused: only esc gets through
      clr_acc();
      repeat (5) step(6, 1, 0, 1);
      step(0, 0, 0, 1);
      repeat (4) step(1, 0, 0, 1);
      repeat (3) step(0, 0, 1, 1);
      chk("paused_pause", 32'(acc[1]), 1);
      chk("paused_other", 32'(acc[6] + acc[7]), 0);
      // reset mid-REPEAT with an action presented, SOFT_DROP held through release
      repeat (8) step(5, 0, 1, 1);
      repeat (3) step(5, 0, 1, 0);
      chk("pre_rst_valid", 32'(action_valid), 1);
      key = 3'd4;
      do_reset();
      step(4, 0, 1, 1);
      step(4, 0, 1, 1);
      chk("soft_after_rst", {29'd0, action_valid, action[1:0]}, 32'd4);
      chk("soft_code", 32'(action), 4);
      repeat (3) step(0, 0, 1, 1);
      // random traffic
      k = 0; e = 1;
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 7) == 0) k = $urandom_range(0, 7);
         if ($urandom_range(0, 49) == 0) e = !e;
         if ($urandom_range(0, 299) == 0) do_reset();
         step(k, $urandom_range(0, 4) == 0, e, $urandom_range(0, 3) != 0);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
